// File: rtl/pool_seq_ctrl.sv
// Row sequencer for the pooling unit: streams rows from the input RAM
// through the pool and writes the pooled rows back to the output RAM.
module pool_seq_ctrl #(
    parameter int DWIDTH      = 16,
    parameter int DESIGN_SIZE = 32,
    parameter int AWIDTH      = 10
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic [2:0]                    window_size,
    input  logic [15:0]                   num_rows,
    input  logic [AWIDTH-1:0]             src_addr,
    input  logic [AWIDTH-1:0]             dst_addr,
    input  logic [15:0]                   stride,
    output logic                          rd_en,
    output logic [AWIDTH-1:0]             rd_addr,
    input  logic [DESIGN_SIZE*DWIDTH-1:0] rd_data,
    output logic                          enable_pool,
    output logic [2:0]                    pool_window_size,
    output logic                          pool_in_valid,
    output logic [DESIGN_SIZE*DWIDTH-1:0] pool_in_data,
    input  logic                          pool_out_valid,
    input  logic [DESIGN_SIZE*DWIDTH-1:0] pool_out_data,
    output logic                          wr_en,
    output logic [AWIDTH-1:0]             wr_addr,
    output logic [DESIGN_SIZE*DWIDTH-1:0] wr_data,
    output logic                          busy,
    output logic                          done,
    output logic                          error
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_READ  = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_FIN   = 2'd3;

    logic [1:0]        state;
    logic [2:0]        win_q;
    logic [15:0]       nrows_q;
    logic [15:0]       stride_q;
    logic [15:0]       rd_cnt;
    logic [15:0]       wr_cnt;
    logic [AWIDTH-1:0] rd_ptr;
    logic [AWIDTH-1:0] wr_ptr;
    logic [3:0]        wd_cnt;
    logic              piv_q;
    logic              err_q;
    logic              done_q;

    logic              cfg_ok;
    logic              active;
    logic              wr_fire;
    logic              last_rd;
    logic              wr_complete;
    logic [AWIDTH-1:0] stride_a;

    assign cfg_ok = ((window_size == 3'd1) ||
                     (window_size == 3'd2) ||
                     (window_size == 3'd4)) &&
                    (num_rows != 16'd0);

    assign active   = (state == S_READ) || (state == S_DRAIN);
    assign stride_a = AWIDTH'(stride_q);
    assign last_rd  = (rd_cnt == nrows_q - 16'd1);

    // Write counter saturates at num_rows; reset cycle never writes.
    assign wr_fire = !reset && active && pool_out_valid &&
                     (wr_cnt != nrows_q);

    assign wr_complete = (wr_cnt == nrows_q) ||
                         (wr_fire && (wr_cnt + 16'd1 == nrows_q));

    assign rd_en   = !reset && (state == S_READ);
    assign rd_addr = (state == S_READ) ? rd_ptr : '0;

    assign pool_in_valid = piv_q;
    assign pool_in_data  = rd_data;

    assign busy             = (state != S_IDLE);
    assign enable_pool      = busy;
    assign pool_window_size = busy ? win_q : 3'd0;

    assign wr_en   = wr_fire;
    assign wr_addr = active ? wr_ptr : '0;
    assign wr_data = pool_out_data;

    assign done  = (state == S_FIN) || done_q;
    assign error = err_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            win_q    <= '0;
            nrows_q  <= '0;
            stride_q <= '0;
            rd_cnt   <= '0;
            wr_cnt   <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            wd_cnt   <= '0;
            piv_q    <= 1'b0;
            err_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            piv_q  <= rd_en;
            err_q  <= 1'b0;
            done_q <= 1'b0;
            if (wr_fire) begin
                wr_cnt <= wr_cnt + 16'd1;
                wr_ptr <= wr_ptr + stride_a;
            end
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        if (cfg_ok) begin
                            win_q    <= window_size;
                            nrows_q  <= num_rows;
                            stride_q <= stride;
                            rd_ptr   <= src_addr;
                            wr_ptr   <= dst_addr;
                            rd_cnt   <= '0;
                            wr_cnt   <= '0;
                            state    <= S_READ;
                        end else begin
                            err_q  <= 1'b1;
                            done_q <= 1'b1;
                        end
                    end
                end
                S_READ: begin
                    rd_ptr <= rd_ptr + stride_a;
                    rd_cnt <= rd_cnt + 16'd1;
                    wd_cnt <= '0;
                    if (last_rd) state <= S_DRAIN;
                end
                S_DRAIN: begin
                    if (wr_complete) begin
                        state <= S_FIN;
                    end else if (wd_cnt == 4'd15) begin
                        // Pool stopped answering; give up and report.
                        state  <= S_IDLE;
                        err_q  <= 1'b1;
                        done_q <= 1'b1;
                    end else begin
                        wd_cnt <= wd_cnt + 4'd1;
                    end
                end
                S_FIN: state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pool_seq_ctrl.sv
// Scoreboard bench for pool_seq_ctrl: directed runs push expected reads,
// writes and done pulses; a negedge monitor pops and compares them.
module tb_pool_seq_ctrl;

    localparam int DW = 16;
    localparam int DS = 32;
    localparam int AW = 10;
    localparam int RW = DS * DW;

    typedef struct {
        logic [AW-1:0] addr;
        logic [RW-1:0] data;
        int            cyc;
    } ev_t;

    typedef struct {
        logic err;
        int   cyc;
    } dn_t;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [2:0]    window_size = '0;
    logic [15:0]   num_rows = '0;
    logic [AW-1:0] src_addr = '0;
    logic [AW-1:0] dst_addr = '0;
    logic [15:0]   stride = '0;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [RW-1:0] rd_data = '0;
    logic          enable_pool;
    logic [2:0]    pool_window_size;
    logic          pool_in_valid;
    logic [RW-1:0] pool_in_data;
    logic          pool_out_valid = 1'b0;
    logic [RW-1:0] pool_out_data = '0;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [RW-1:0] wr_data;
    logic          busy;
    logic          done;
    logic          error;

    int  cyc = 0;
    int  t0 = 0;
    int  checks = 0;
    int  failures = 0;
    logic stall = 1'b0;

    ev_t rd_q[$];
    ev_t wr_q[$];
    dn_t dn_q[$];

    pool_seq_ctrl #(.DWIDTH(DW), .DESIGN_SIZE(DS), .AWIDTH(AW)) dut (
        .clk(clk), .reset(reset), .start(start),
        .window_size(window_size), .num_rows(num_rows),
        .src_addr(src_addr), .dst_addr(dst_addr), .stride(stride),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .enable_pool(enable_pool), .pool_window_size(pool_window_size),
        .pool_in_valid(pool_in_valid), .pool_in_data(pool_in_data),
        .pool_out_valid(pool_out_valid), .pool_out_data(pool_out_data),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .busy(busy), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [RW-1:0] fdata(input logic [AW-1:0] a);
        logic [RW-1:0] r;
        for (int i = 0; i < DS; i++)
            r[i*DW +: DW] = 16'(a) + 16'(i * 3);
        return r;
    endfunction

    // RAM with one-cycle read latency and a one-cycle "pool" that inverts.
    always @(posedge clk) begin
        rd_data        <= fdata(rd_addr);
        pool_out_valid <= pool_in_valid && !stall;
        pool_out_data  <= ~pool_in_data;
    end

    always @(negedge clk) begin
        ev_t e;
        dn_t d;
        if (rd_en === 1'b1) begin
            checks++;
            if (rd_q.size() == 0) begin
                failures++;
                $display("FAIL rd_unexpected addr=%0h cyc=%0d", rd_addr, cyc);
            end else begin
                e = rd_q.pop_front();
                if (rd_addr !== e.addr || cyc != e.cyc) begin
                    failures++;
                    $display("FAIL rd actual addr=%0h cyc=%0d required addr=%0h cyc=%0d",
                             rd_addr, cyc, e.addr, e.cyc);
                end
            end
        end
        if (wr_en === 1'b1) begin
            checks++;
            if (wr_q.size() == 0) begin
                failures++;
                $display("FAIL wr_unexpected addr=%0h cyc=%0d", wr_addr, cyc);
            end else begin
                e = wr_q.pop_front();
                if (wr_addr !== e.addr || wr_data !== e.data || cyc != e.cyc) begin
                    failures++;
                    $display("FAIL wr actual addr=%0h cyc=%0d data_ok=%0b required addr=%0h cyc=%0d",
                             wr_addr, cyc, wr_data === e.data, e.addr, e.cyc);
                end
            end
        end
        if (done === 1'b1 || error === 1'b1) begin
            checks++;
            if (dn_q.size() == 0) begin
                failures++;
                $display("FAIL done_unexpected done=%0b error=%0b cyc=%0d", done, error, cyc);
            end else begin
                d = dn_q.pop_front();
                if (done !== 1'b1 || error !== d.err || cyc != d.cyc) begin
                    failures++;
                    $display("FAIL done actual done=%0b err=%0b cyc=%0d required done=1 err=%0b cyc=%0d",
                             done, error, cyc, d.err, d.cyc);
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic launch(input logic [2:0] w, input logic [15:0] n,
                          input logic [AW-1:0] s, input logic [AW-1:0] d,
                          input logic [15:0] st);
        @(posedge clk); #1;
        window_size = w;
        num_rows    = n;
        src_addr    = s;
        dst_addr    = d;
        stride      = st;
        start       = 1'b1;
        t0          = cyc;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic push_reads(input int n, input logic [AW-1:0] s, input logic [15:0] st);
        for (int k = 0; k < n; k++)
            rd_q.push_back('{AW'(int'(s) + k * int'(st)), '0, t0 + 1 + k});
    endtask

    task automatic push_writes(input int n, input logic [AW-1:0] s,
                               input logic [AW-1:0] d, input logic [15:0] st);
        for (int m = 0; m < n; m++)
            wr_q.push_back('{AW'(int'(d) + m * int'(st)),
                             ~fdata(AW'(int'(s) + m * int'(st))), t0 + 3 + m});
    endtask

    task automatic push_run(input int n, input logic [AW-1:0] s,
                            input logic [AW-1:0] d, input logic [15:0] st);
        push_reads(n, s, st);
        push_writes(n, s, d, st);
        dn_q.push_back('{1'b0, t0 + n + 3});
    endtask

    task automatic drained(input string nm);
        chk({nm, "_rd_left"}, 64'(rd_q.size()), 64'd0);
        chk({nm, "_wr_left"}, 64'(wr_q.size()), 64'd0);
        chk({nm, "_done_left"}, 64'(dn_q.size()), 64'd0);
        rd_q.delete();
        wr_q.delete();
        dn_q.delete();
    endtask

    task automatic idle_outs(input string nm);
        chk({nm, "_rd_en"}, 64'(rd_en), 64'd0);
        chk({nm, "_wr_en"}, 64'(wr_en), 64'd0);
        chk({nm, "_busy"}, 64'(busy), 64'd0);
        chk({nm, "_enable_pool"}, 64'(enable_pool), 64'd0);
        chk({nm, "_pool_win"}, 64'(pool_window_size), 64'd0);
        chk({nm, "_pool_in_valid"}, 64'(pool_in_valid), 64'd0);
        chk({nm, "_rd_addr"}, 64'(rd_addr), 64'd0);
        chk({nm, "_wr_addr"}, 64'(wr_addr), 64'd0);
        chk({nm, "_done"}, 64'(done), 64'd0);
        chk({nm, "_error"}, 64'(error), 64'd0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        idle_outs("reset");

        // Nominal window-2 run
        launch(3'd2, 16'd4, 10'h010, 10'h100, 16'd1);
        push_run(4, 10'h010, 10'h100, 16'd1);
        @(negedge clk);
        chk("run_busy", 64'(busy), 64'd1);
        chk("run_enable_pool", 64'(enable_pool), 64'd1);
        chk("run_pool_win", 64'(pool_window_size), 64'd2);
        repeat (12) @(posedge clk);
        @(negedge clk);
        idle_outs("after_run");
        drained("nominal");

        // Read and write addresses wrap at 2^AWIDTH
        launch(3'd4, 16'd4, 10'h3FE, 10'h3FD, 16'd1);
        push_run(4, 10'h3FE, 10'h3FD, 16'd1);
        repeat (12) @(posedge clk);
        drained("wrap");

        // Illegal configurations
        launch(3'd3, 16'd2, 10'h000, 10'h000, 16'd1);
        dn_q.push_back('{1'b1, t0 + 1});
        repeat (6) @(posedge clk);
        drained("bad_window");
        launch(3'd2, 16'd0, 10'h000, 10'h000, 16'd1);
        dn_q.push_back('{1'b1, t0 + 1});
        repeat (6) @(posedge clk);
        drained("zero_rows");

        // Start and config changes while busy are ignored
        launch(3'd1, 16'd5, 10'h020, 10'h200, 16'd4);
        push_run(5, 10'h020, 10'h200, 16'd4);
        @(posedge clk); #1;
        start       = 1'b1;
        window_size = 3'd4;
        src_addr    = 10'h300;
        stride      = 16'd7;
        num_rows    = 16'd9;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        chk("busy_pool_win", 64'(pool_window_size), 64'd1);
        repeat (14) @(posedge clk);
        drained("restart");

        // Pool never answers: watchdog fires 16 cycles into DRAIN
        stall = 1'b1;
        launch(3'd2, 16'd3, 10'h050, 10'h150, 16'd1);
        push_reads(3, 10'h050, 16'd1);
        dn_q.push_back('{1'b1, t0 + 3 + 1 + 16});
        repeat (28) @(posedge clk);
        drained("watchdog");
        stall = 1'b0;
        repeat (3) @(posedge clk);

        // Reset in cycle 3 of an 8-row run
        launch(3'd2, 16'd8, 10'h040, 10'h080, 16'd1);
        push_reads(2, 10'h040, 16'd1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        idle_outs("abort");
        repeat (15) @(posedge clk);
        drained("abort");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pool_seq_ctrl.md
POOL_SEQ_CTRL -- requirements
Module: pool_seq_ctrl

Interface
REQ-001 SHALL have parameter DWIDTH, default 16, element width in bits.
REQ-002 SHALL have parameter DESIGN_SIZE, default 32, elements per row.
REQ-003 SHALL have parameter AWIDTH, default 10, RAM address width.
REQ-004 Port clk  in  1  clock, all logic on rising edge.
REQ-005 Port reset  in  1  reset, synchronous, active-high.
REQ-006 Port start  in  1  launch request, sampled in IDLE only.
REQ-007 Port window_size  in  3  pooling window (1, 2 or 4), latched at start.
REQ-008 Port num_rows  in  16  rows to process, latched at start.
REQ-009 Port src_addr / dst_addr  in  AWIDTH each  base addresses, latched at start.
REQ-010 Port stride  in  16  address increment per row, latched at start.
REQ-011 Port rd_en / rd_addr  out  1 / AWIDTH  input-RAM read request and address.
REQ-012 Port rd_data  in  DESIGN_SIZE*DWIDTH  read data, valid one cycle after rd_en.
REQ-013 Port enable_pool / pool_window_size  out  1 / 3  pool configuration.
REQ-014 Port pool_in_valid / pool_in_data  out  1 / DESIGN_SIZE*DWIDTH  row into pool.
REQ-015 Port pool_out_valid / pool_out_data  in  1 / DESIGN_SIZE*DWIDTH  row from pool.
REQ-016 Port wr_en / wr_addr / wr_data  out  1 / AWIDTH / DESIGN_SIZE*DWIDTH  output-RAM write.
REQ-017 Port busy / done / error  out  1 each  status; done and error are 1-cycle pulses.

Function
REQ-018 FSM states IDLE, READ, DRAIN, FIN; IDLE->READ on start with legal config; READ->DRAIN after last read; DRAIN->FIN when write count equals num_rows; FIN->IDLE unconditionally.
REQ-019 Legal config: window_size in {1,2,4} and num_rows != 0; otherwise start -> error and done pulse together the next cycle, no reads or writes, stay IDLE.
REQ-020 In READ, rd_en high every cycle for exactly num_rows cycles; rd_addr = src_addr + k*stride for k = 0..num_rows-1, truncated to AWIDTH (wraps modulo 2^AWIDTH).
REQ-021 pool_in_valid = rd_en delayed one cycle; pool_in_data = rd_data passed combinationally.
REQ-022 enable_pool high and pool_window_size = latched window_size while busy; both 0 in IDLE.
REQ-023 wr_en = pool_out_valid while in READ or DRAIN; wr_data = pool_out_data; wr_addr = dst_addr + m*stride for m-th write (m from 0), truncated to AWIDTH.
REQ-024 pool_out_valid outside READ/DRAIN is ignored, no write.
REQ-025 Writes beyond num_rows are suppressed (write counter saturates at num_rows).
REQ-026 Timing: start high in cycle 0 -> rd_en cycles 1..N, pool_in_valid 2..N+1, wr_en with pool_out_valid (nominally 3..N+2), done pulse in FIN (nominally cycle N+3).
REQ-027 DRAIN watchdog: 16 cycles in DRAIN without completing -> error and done pulse, return to IDLE.
REQ-028 busy high in READ, DRAIN, FIN; low in IDLE.
REQ-029 start while busy is ignored; config inputs changing while busy have no effect.

Reset
REQ-030 On reset: state IDLE; rd_en, pool_in_valid, enable_pool, wr_en, busy, done, error = 0; pool_window_size, rd_addr, wr_addr = 0; counters cleared.
REQ-031 Reset mid-operation aborts immediately; no write issued in the reset cycle or after; no done pulse.

Verification
REQ-032 window 2, N=4, src=0x010, dst=0x100, stride=1 -> reads 0x010..0x013 cycles 1..4, writes 0x100..0x103 cycles 3..6, done cycle 7.
REQ-033 src=0x3FE, stride=1, N=4 -> rd_addr 0x3FE, 0x3FF, 0x000, 0x001.
REQ-034 window 3 or num_rows 0 -> error+done one cycle after start, rd_en and wr_en never asserted.
REQ-035 Reset asserted cycle 3 of N=8 run -> all outputs 0 next cycle, no further wr_en, no done.
REQ-036 pool_out_valid held low after reads -> error+done 16 cycles after entering DRAIN.
REQ-037 start pulsed while busy, stride=4 -> ignored; addresses step by 4, single done.
